// File: rtl/ssd1306_spi_arbiter.sv
// Arbitrates one spi_master between a command source (D/C=0) and a data source (D/C=1).
// Optional WAIT watchdog with sticky err: define SSD1306_ARB_TIMEOUT_EN.
module ssd1306_spi_arbiter #(
    parameter int DC_SETUP       = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       dat_valid,
    input  logic [7:0] dat_data,
    input  logic       dat_last,
    output logic       dat_ready,
    output logic       spi_wr,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       oled_dc,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, GAP} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        locked;
    logic [7:0]  burst_cnt;
    logic        preempt;
    logic        wd_expire;
    logic        byte_done;

    generate
        if (DC_SETUP < 1 || DC_SETUP > 65536 || GAP_CYCLES < 0 || GAP_CYCLES > 65536 ||
            MAX_BURST < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
            $error("ssd1306_spi_arbiter: parameter out of range");
        end
    endgenerate

    // A command may break a locked burst only once the fairness limit is reached
    assign preempt   = locked & cmd_valid & ({24'd0, burst_cnt} >= MAX_BURST);
    assign cmd_ready = rst_n & (state == IDLE) & cmd_valid & (!locked | preempt);
    assign dat_ready = rst_n & (state == IDLE) & dat_valid & !cmd_ready;
    assign busy      = (state != IDLE) | locked;
    assign byte_done = ((state == SEND || state == WAIT) & spi_done) | wd_expire;

`ifdef SSD1306_ARB_TIMEOUT_EN
    logic [15:0] wd;
    logic        err_q;

    assign wd_expire = (state == WAIT) & !spi_done & (wd == 16'(TIMEOUT_CYCLES - 1));
    assign err       = err_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= (state == WAIT) ? wd + 16'd1 : 16'd0;
            err_q <= err_q | wd_expire;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            locked    <= 1'b0;
            burst_cnt <= '0;
            spi_wr    <= 1'b0;
            spi_data  <= 8'h00;
            oled_dc   <= 1'b0;
        end else begin
            spi_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready) begin
                        spi_data <= cmd_data;
                        oled_dc  <= 1'b0;
                        cnt      <= 16'(DC_SETUP - 1);
                        state    <= SETUP;
                        if (preempt) begin
                            locked    <= 1'b0;
                            burst_cnt <= '0;
                        end
                    end else if (dat_ready) begin
                        spi_data <= dat_data;
                        oled_dc  <= 1'b1;
                        cnt      <= 16'(DC_SETUP - 1);
                        state    <= SETUP;
                        if (dat_last) begin
                            locked    <= 1'b0;
                            burst_cnt <= '0;
                        end else begin
                            locked <= 1'b1;
                            if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= SEND;
                        spi_wr <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SEND, WAIT: begin
                    if (byte_done) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= 16'(GAP_CYCLES - 1);
                        end
                        // A stalled engine abandons the burst so commands are not starved
                        if (wd_expire) begin
                            locked    <= 1'b0;
                            burst_cnt <= '0;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                GAP: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_arbiter.sv
// Directed bench for ssd1306_spi_arbiter with a small spi_master responder model.
module tb_ssd1306_spi_arbiter;

    localparam int LAT = 4;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       cmd_valid, dat_valid, dat_last;
    logic [7:0] cmd_data, dat_data;
    logic       cmd_ready, dat_ready;
    logic       spi_wr, spi_done, oled_dc, busy, err;
    logic [7:0] spi_data;
    logic       auto_en, auto_done, manual_done;
    int         wcnt;
    int         wr_cnt;
    logic [8:0] q[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk_50M = ~clk_50M;

    assign spi_done = auto_done | manual_done;

    ssd1306_spi_arbiter #(
        .DC_SETUP(2), .GAP_CYCLES(1), .MAX_BURST(16), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .dat_valid(dat_valid), .dat_data(dat_data), .dat_last(dat_last), .dat_ready(dat_ready),
        .spi_wr(spi_wr), .spi_data(spi_data), .spi_done(spi_done),
        .oled_dc(oled_dc), .busy(busy), .err(err)
    );

    // spi_master model: done pulse LAT cycles after the write strobe
    always @(negedge clk_50M) begin
        auto_done = 1'b0;
        if (!rst_n) wcnt = 0;
        else if (spi_wr && auto_en) wcnt = LAT;
        else if (wcnt > 0) begin
            wcnt = wcnt - 1;
            if (wcnt == 0) auto_done = 1'b1;
        end
    end

    always @(negedge clk_50M) begin
        if (spi_wr) begin
            q.push_back({oled_dc, spi_data});
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        @(negedge clk_50M);
        cmd_valid = 1'b1; cmd_data = b;
        #1;
        while (!cmd_ready && n < 2000) begin @(negedge clk_50M); #1; n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge clk_50M);
        cmd_valid = 1'b0;
    endtask

    task automatic send_dat(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk_50M);
        dat_valid = 1'b1; dat_data = b; dat_last = last;
        #1;
        while (!dat_ready && n < 2000) begin @(negedge clk_50M); #1; n++; end
        chk("dat_accept", dat_ready, 1);
        @(negedge clk_50M);
        dat_valid = 1'b0; dat_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin @(negedge clk_50M); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int base, snap;
        rst_n = 1'b0; cmd_valid = 1'b1; dat_valid = 1'b1; dat_last = 1'b0;
        cmd_data = 8'h00; dat_data = 8'h00;
        auto_en = 1'b1; manual_done = 1'b0; wr_cnt = 0; wcnt = 0; auto_done = 1'b0;

        // Reset values, readies forced low while in reset
        repeat (3) @(negedge clk_50M);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_dat_ready", dat_ready, 0);
        chk("rst_spi_wr", spi_wr, 0);
        chk("rst_spi_data", spi_data, 8'h00);
        chk("rst_oled_dc", oled_dc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        cmd_valid = 1'b0; dat_valid = 1'b0;
        @(negedge clk_50M); rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // Single command byte with exact cycle timing
        cmd_valid = 1'b1; cmd_data = 8'hAF;
        #1 chk("t0_cmd_ready", cmd_ready, 1);
        @(negedge clk_50M); cmd_valid = 1'b0;                 // t0+1
        chk("t1_oled_dc", oled_dc, 0);
        chk("t1_busy", busy, 1);
        chk("t1_spi_wr", spi_wr, 0);
        @(negedge clk_50M); chk("t2_spi_wr", spi_wr, 0);       // t0+2
        @(negedge clk_50M);                                     // t0+3
        chk("t3_spi_wr", spi_wr, 1);
        chk("t3_spi_data", spi_data, 8'hAF);
        @(negedge clk_50M); chk("t4_spi_wr", spi_wr, 0);
        repeat (4) @(negedge clk_50M);                          // t0+8: GAP
        chk("t8_busy_gap", busy, 1);
        @(negedge clk_50M); chk("t9_busy_idle", busy, 0);      // t0+9
        chk("one_strobe", wr_cnt, 1);

        // Simultaneous offer, unlocked: command first, then data
        base = q.size();
        fork
            send_cmd(8'h11);
            send_dat(8'h22, 1'b1);
            begin
                @(negedge clk_50M); #1;
                chk("sim_cmd_ready", cmd_ready, 1);
                chk("sim_dat_ready", dat_ready, 0);
            end
        join
        wait_idle();
        chk("sim_log_size", q.size(), base + 2);
        if (q.size() >= base + 2) begin
            chk("sim_first", q[base], {1'b0, 8'h11});
            chk("sim_second", q[base + 1], {1'b1, 8'h22});
        end
        chk("sim_oled_dc", oled_dc, 1);

        // 20-byte burst with command pending from byte 3: preempts after byte 16
        base = q.size();
        fork
            for (int i = 1; i <= 20; i++) send_dat(8'(i), i == 20);
            begin
                int n = 0;
                while (q.size() < base + 3 && n < 2000) begin @(negedge clk_50M); n++; end
                send_cmd(8'hC3);
            end
        join
        wait_idle();
        chk("burst_log_size", q.size(), base + 21);
        for (int i = 0; i < 21 && base + i < q.size(); i++) begin
            logic [8:0] e;
            if (i < 16)       e = {1'b1, 8'(i + 1)};
            else if (i == 16) e = {1'b0, 8'hC3};
            else              e = {1'b1, 8'(i)};
            chk($sformatf("burst_%0d", i), q[base + i], e);
        end

        // Stray spi_done in IDLE and in GAP
        snap = wr_cnt;
        @(negedge clk_50M); manual_done = 1'b1;
        @(negedge clk_50M); manual_done = 1'b0;
        repeat (3) @(negedge clk_50M);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_nowr", wr_cnt, snap);
        send_cmd(8'h44);                                        // returns at t0+1
        repeat (7) @(negedge clk_50M);                          // t0+8: GAP
        chk("gap_busy", busy, 1);
        manual_done = 1'b1;
        @(negedge clk_50M); manual_done = 1'b0;                 // t0+9
        chk("gap_done_idle", busy, 0);
        repeat (5) @(negedge clk_50M);
        chk("gap_done_wr", wr_cnt, snap + 1);

        // Reset in WAIT on a non-last data byte
        auto_en = 1'b0;
        send_dat(8'hA5, 1'b0);
        repeat (5) @(negedge clk_50M);
        chk("wait_busy", busy, 1);
        chk("wait_oled_dc", oled_dc, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_spi_data", spi_data, 8'h00);
        chk("ar_oled_dc", oled_dc, 0);
        chk("ar_busy", busy, 0);
        chk("ar_spi_wr", spi_wr, 0);
        @(negedge clk_50M); rst_n = 1'b1; auto_en = 1'b1;
        snap = wr_cnt;
        repeat (20) @(negedge clk_50M);
        chk("ar_no_wr", wr_cnt, snap);
        chk("ar_unlocked", busy, 0);
        base = q.size();
        send_cmd(8'h3C);
        wait_idle();
        chk("ar_cmd_sent", (q.size() > base) ? q[base] : 9'h1FF, {1'b0, 8'h3C});

`ifdef SSD1306_ARB_TIMEOUT_EN
        auto_en = 1'b0;
        send_cmd(8'h77);                                        // returns at t0+1
        repeat (66) @(negedge clk_50M);                         // t0+67: last WAIT cycle
        chk("to_err_before", err, 0);
        @(negedge clk_50M);
        chk("to_err_set", err, 1);
        auto_en = 1'b1;
        base = q.size();
        send_cmd(8'h78);
        wait_idle();
        chk("to_next_cmd", (q.size() > base) ? q[base] : 9'h1FF, {1'b0, 8'h78});
        chk("to_err_sticky", err, 1);
`else
        auto_en = 1'b0;
        send_cmd(8'h77);
        repeat (100) @(negedge clk_50M);
        chk("nto_err", err, 0);
        chk("nto_still_wait", busy, 1);
        rst_n = 1'b0;
        @(negedge clk_50M); rst_n = 1'b1; auto_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd1306_spi_arbiter.md
# ssd1306_spi_arbiter

Shares the single `spi_master` byte engine between two requesters: a command source (init/config sequencer, D/C=0) and a data source (framebuffer streamer, D/C=1). It sequences each byte as D/C setup, write strobe, wait for completion, then an inter-byte gap. It keeps data bursts atomic, and a fairness limit lets a pending command break a long burst. It sits between the SSD1306 control logic and `spi_master` and owns the `oled_dc` pin.

## Interface
- `DC_SETUP`, 2: cycles `oled_dc` is held stable before `spi_wr` (≥1).
- `GAP_CYCLES`, 1: idle cycles after each byte completes (0 allowed).
- `MAX_BURST`, 16: data bytes granted in one burst before a pending command may preempt (≥1).
- `TIMEOUT_CYCLES`, 4096: watchdog limit for WAIT; used only with `SSD1306_ARB_TIMEOUT_EN`.

- `clk_50M` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command byte offered.
- `cmd_data` in 8: command byte.
- `cmd_ready` out 1: command byte accepted this cycle when high with `cmd_valid`.
- `dat_valid` in 1: data byte offered.
- `dat_data` in 8: data byte.
- `dat_last` in 1: last byte of the data burst.
- `dat_ready` out 1: data byte accepted this cycle.
- `spi_wr` out 1: one-cycle start strobe to `spi_master`.
- `spi_data` out 8: byte presented to `spi_master`; stable from accept until next accept.
- `spi_done` in 1: one-cycle pulse when the byte is shifted out.
- `oled_dc` out 1: SSD1306 D/C pin (0 = command, 1 = data).
- `busy` out 1: state ≠ IDLE or burst lock held.
- `err` out 1: sticky timeout flag (constant 0 without the macro).

## Operation
- States: IDLE, SETUP, SEND, WAIT, GAP.
- Ready outputs are combinational and forced 0 while `rst_n`=0.
- Priority in IDLE:
  - not locked: command wins over data.
  - locked: only data accepted, unless `cmd_valid`=1 and `burst_cnt`≥`MAX_BURST`; then command preempts, and `locked` and `burst_cnt` clear.
- `cmd_ready` = IDLE & `cmd_valid` & (!`locked` | preempt).
- `dat_ready` = IDLE & `dat_valid` & !`cmd_ready`.
- On accept:
  - `spi_data` takes the byte.
  - `oled_dc` takes 0 (cmd) or 1 (dat).
  - Counter loads `DC_SETUP`−1; go to SETUP.
- Data accept with `dat_last`=0: `locked`=1, `burst_cnt`+1 (saturating, 8 bits).
- Data accept with `dat_last`=1: `locked`=0, `burst_cnt`=0.
- SETUP: count down to 0, then SEND.
- SEND: `spi_wr`=1 for exactly this cycle, then WAIT.
- WAIT: exit on `spi_done`. `spi_done` arriving in the SEND cycle is also honoured.
  - `GAP_CYCLES`=0: go to IDLE.
  - otherwise: go to GAP, counter loads `GAP_CYCLES`−1.
- GAP: count down to 0, then IDLE.
- `spi_done` outside SEND/WAIT is ignored.
- A locked arbiter with no `dat_valid` waits in IDLE indefinitely. Commands stay blocked until the burst count reaches `MAX_BURST`.
- Reset mid-transfer: all state cleared immediately; the in-flight byte is abandoned and no `spi_wr` is reissued.

## Timing
- Reset values: `spi_wr`=0, `spi_data`=8'h00, `oled_dc`=0, `busy`=0, `err`=0. Both readies are 0 while in reset. State is IDLE, `locked`=0, `burst_cnt`=0.
- Accept edge t0; `oled_dc` valid from t0.
- `spi_wr` high in cycle t0+`DC_SETUP`+1, i.e. SETUP occupies exactly `DC_SETUP` cycles.
- Next accept: earliest `GAP_CYCLES`+1 cycles after the cycle in which `spi_done` is sampled.
- With `DC_SETUP`=2, `GAP_CYCLES`=1 and `spi_done` 16 cycles after `spi_wr`, byte period = 1+2+1+16+1+… = 21 cycles.
- `oled_dc` changes only on accept edges, never during SETUP/SEND/WAIT/GAP.

## Configuration
- `SSD1306_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts WAIT cycles.
  - Reaching `TIMEOUT_CYCLES` without `spi_done` sets `err`=1, which stays set until reset.
  - The arbiter then goes to GAP as if done, and `locked` and `burst_cnt` clear.
- Undefined: no watchdog logic; WAIT holds until `spi_done`; `err` tied to 0.

## Test plan
- Reset, then `cmd_valid` with 8'hAF: `cmd_ready` pulses once; `oled_dc`=0; `spi_wr` 3 cycles later with `spi_data`=8'hAF; after `spi_done`, 1 gap cycle, then IDLE, `busy`=0.
- `cmd_valid` and `dat_valid` asserted in the same IDLE cycle, unlocked: command is sent first; the data byte follows with `oled_dc` going 0→1 at its accept edge.
- 20-byte data burst (`dat_last` on byte 20), with a command arriving after byte 3 and `MAX_BURST`=16: bytes 1–16 are sent, then the command (`oled_dc`=0), then bytes 17–20.
- `spi_done` pulses while in IDLE and GAP: no state change and no extra `spi_wr`.
- `rst_n` dropped during WAIT: outputs return to reset values asynchronously; after release, no `spi_wr` occurs until a new accept.
- With `SSD1306_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, `spi_done` withheld: `err`=1 64 cycles into WAIT; next `cmd_valid` is accepted after the gap.
